// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
//   Bundles the control, preset and status signals of the HH:MM:SS countdown
//   timer. clk and clr are kept out of the bundle and wired as plain ports.
//
//   Control   : en (one-second tick), load, start, stop
//   Preset    : sd0/md0/hd0 units digits (4b), sd1/md1/hd1 tens digits (3b)
//   Status    : sq0/mq0/hq0 units digits (4b), sq1/mq1 tens (3b), hq1 (2b),
//               state (2b: IDLE=00 RUN=01 DONE=10), done, done_p
//
//   master : the controlling side (drives control/preset, reads status)
//   slave  : the timer itself
// ---------------------------------------------------------------------------
interface countdown_timer_if;
  logic       en;
  logic       load;
  logic       start;
  logic       stop;

  logic [3:0] sd0;
  logic [3:0] md0;
  logic [3:0] hd0;
  logic [2:0] sd1;
  logic [2:0] md1;
  logic [2:0] hd1;

  logic [3:0] sq0;
  logic [3:0] mq0;
  logic [3:0] hq0;
  logic [2:0] sq1;
  logic [2:0] mq1;
  logic [1:0] hq1;
  logic [1:0] state;
  logic       done;
  logic       done_p;

  modport master (
    output en, load, start, stop,
    output sd0, md0, hd0, sd1, md1, hd1,
    input  sq0, mq0, hq0, sq1, mq1, hq1,
    input  state, done, done_p
  );

  modport slave (
    input  en, load, start, stop,
    input  sd0, md0, hd0, sd1, md1, hd1,
    output sq0, mq0, hq0, sq1, mq1, hq1,
    output state, done, done_p
  );
endinterface

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   BCD HH:MM:SS countdown timer (00:00:00 .. 23:59:59).
//
//   Ports:
//     clk  - system clock, all state changes on the rising edge
//     clr  - asynchronous active-high clear: digits 0, IDLE, done/done_p 0
//     bus  - countdown_timer_if.slave
//              en     one-second tick enable
//              load   preset request (clamped to a legal time), -> IDLE
//              start  IDLE -> RUN when the value is nonzero
//              stop   RUN  -> IDLE, value held
//              sd*/md*/hd* preset digits, sq*/mq*/hq* current digits
//              state  IDLE=00 RUN=01 DONE=10
//              done   high while in DONE
//              done_p single-cycle pulse on entry into DONE
//
//   Per-edge priority: clr > load > stop > start > en.
//   start only acts in IDLE; in RUN it is a no-op, so an en arriving with
//   it still decrements. stop always blocks start/en on the same edge.
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module countdown_timer (
  input  logic               clk,
  input  logic               clr,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t     state_q, state_d;

  logic [3:0] s0_q, s0_d;
  logic [2:0] s1_q, s1_d;
  logic [3:0] m0_q, m0_d;
  logic [2:0] m1_q, m1_d;
  logic [3:0] h0_q, h0_d;
  logic [1:0] h1_q, h1_d;
  logic       done_q, done_d;
  logic       done_p_q, done_p_d;

  // Clamped preset digits.
  logic [3:0] ld_s0, ld_m0, ld_h0;
  logic [2:0] ld_s1, ld_m1;
  logic [1:0] ld_h1;

  // Current value minus one second.
  logic [3:0] dec_s0, dec_m0, dec_h0;
  logic [2:0] dec_s1, dec_m1;
  logic [1:0] dec_h1;

  logic       cur_zero;
  logic       dec_zero;

  // -------------------------------------------------------------------------
  // Preset clamp. The hour units limit depends on the (clamped) hour tens:
  // 0x/1x allow up to 9, 2x allows up to 3; any tens >= 2 becomes 2.
  // -------------------------------------------------------------------------
  always_comb begin
    ld_s0 = (bus.sd0 > 4'd9) ? 4'd9 : bus.sd0;
    ld_s1 = (bus.sd1 > 3'd5) ? 3'd5 : bus.sd1;
    ld_m0 = (bus.md0 > 4'd9) ? 4'd9 : bus.md0;
    ld_m1 = (bus.md1 > 3'd5) ? 3'd5 : bus.md1;
    if (bus.hd1 >= 3'd2) begin
      ld_h1 = 2'd2;
      ld_h0 = (bus.hd0 > 4'd3) ? 4'd3 : bus.hd0;
    end else begin
      ld_h1 = bus.hd1[1:0];
      ld_h0 = (bus.hd0 > 4'd9) ? 4'd9 : bus.hd0;
    end
  end

  // -------------------------------------------------------------------------
  // One-second decrement with a borrow chain s0 -> s1 -> m0 -> m1 -> hours.
  // Only used while the value is nonzero, so the hour borrow never needs to
  // go below 00; the hour tens saturates anyway to keep the digit legal.
  // -------------------------------------------------------------------------
  always_comb begin
    dec_s0 = s0_q;
    dec_s1 = s1_q;
    dec_m0 = m0_q;
    dec_m1 = m1_q;
    dec_h0 = h0_q;
    dec_h1 = h1_q;
    if (s0_q != 4'd0) begin
      dec_s0 = s0_q - 4'd1;
    end else begin
      dec_s0 = 4'd9;
      if (s1_q != 3'd0) begin
        dec_s1 = s1_q - 3'd1;
      end else begin
        dec_s1 = 3'd5;
        if (m0_q != 4'd0) begin
          dec_m0 = m0_q - 4'd1;
        end else begin
          dec_m0 = 4'd9;
          if (m1_q != 3'd0) begin
            dec_m1 = m1_q - 3'd1;
          end else begin
            dec_m1 = 3'd5;
            if (h0_q != 4'd0) begin
              dec_h0 = h0_q - 4'd1;
            end else begin
              dec_h0 = 4'd9;
              dec_h1 = (h1_q != 2'd0) ? (h1_q - 2'd1) : 2'd0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    cur_zero = (s0_q == 4'd0) && (s1_q == 3'd0) && (m0_q == 4'd0) &&
               (m1_q == 3'd0) && (h0_q == 4'd0) && (h1_q == 2'd0);
    dec_zero = (dec_s0 == 4'd0) && (dec_s1 == 3'd0) && (dec_m0 == 4'd0) &&
               (dec_m1 == 3'd0) && (dec_h0 == 4'd0) && (dec_h1 == 2'd0);
  end

  // -------------------------------------------------------------------------
  // Next-state / next-value logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    m0_d     = m0_q;
    m1_d     = m1_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    done_p_d = 1'b0;

    if (bus.load) begin
      state_d = ST_IDLE;
      s0_d    = ld_s0;
      s1_d    = ld_s1;
      m0_d    = ld_m0;
      m1_d    = ld_m1;
      h0_d    = ld_h0;
      h1_d    = ld_h1;
    end else if (bus.stop) begin
      // stop consumes the edge: start and en are ignored alongside it.
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end
    end else if (bus.start && (state_q == ST_IDLE)) begin
      // Entering RUN does not decrement on the same edge.
      if (!cur_zero) begin
        state_d = ST_RUN;
      end
    end else if (bus.en && (state_q == ST_RUN) && !cur_zero) begin
      s0_d = dec_s0;
      s1_d = dec_s1;
      m0_d = dec_m0;
      m1_d = dec_m1;
      h0_d = dec_h0;
      h1_d = dec_h1;
      if (dec_zero) begin
        state_d  = ST_DONE;
        done_p_d = 1'b1;
      end
    end

    done_d = (state_d == ST_DONE);
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      s0_q     <= 4'd0;
      s1_q     <= 3'd0;
      m0_q     <= 4'd0;
      m1_q     <= 3'd0;
      h0_q     <= 4'd0;
      h1_q     <= 2'd0;
      done_q   <= 1'b0;
      done_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      m0_q     <= m0_d;
      m1_q     <= m1_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      done_q   <= done_d;
      done_p_q <= done_p_d;
    end
  end

  assign bus.sq0    = s0_q;
  assign bus.sq1    = s1_q;
  assign bus.mq0    = m0_q;
  assign bus.mq1    = m1_q;
  assign bus.hq0    = h0_q;
  assign bus.hq1    = h1_q;
  assign bus.state  = state_q;
  assign bus.done   = done_q;
  assign bus.done_p = done_p_q;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//   Table-driven vectors for the directed scenarios, hand-written sequences
//   for asynchronous clear, then random stimulus checked against a model
//   that keeps the time as a plain count of seconds.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  countdown_timer_if bus();

  countdown_timer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: value in seconds, state as an integer.
  int m_val;
  int m_st;
  bit m_dp;

  typedef struct {
    bit ld, st, sp, en;
    int h1, h0, m1, m0, s1, s0;
    int e_sec;
    int e_st;
    bit e_done;
    bit e_dp;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic int to_s(int h, int m, int s);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic vec_t mk(bit ld, bit st, bit sp, bit en,
                              int h1, int h0, int m1, int m0, int s1, int s0,
                              int eh, int em, int es, int est, bit ed, bit edp);
    vec_t v;
    v.ld = ld; v.st = st; v.sp = sp; v.en = en;
    v.h1 = h1; v.h0 = h0; v.m1 = m1; v.m0 = m0; v.s1 = s1; v.s0 = s0;
    v.e_sec = to_s(eh, em, es);
    v.e_st = est; v.e_done = ed; v.e_dp = edp;
    return v;
  endfunction

  // Legal time (in seconds) that a preset request turns into.
  function automatic int clamp_secs(int h1, int h0, int m1, int m0, int s1, int s0);
    int th, uh, tm, um, ts, us;
    th = (h1 >= 2) ? 2 : h1;
    uh = h0;
    if (th == 2) begin
      if (uh > 3) uh = 3;
    end else if (uh > 9) begin
      uh = 9;
    end
    tm = (m1 > 5) ? 5 : m1;
    um = (m0 > 9) ? 9 : m0;
    ts = (s1 > 5) ? 5 : s1;
    us = (s0 > 9) ? 9 : s0;
    return to_s(th * 10 + uh, tm * 10 + um, ts * 10 + us);
  endfunction

  task automatic model_step(bit ld, bit st, bit sp, bit en,
                            int h1, int h0, int m1, int m0, int s1, int s0);
    m_dp = 1'b0;
    if (ld) begin
      m_val = clamp_secs(h1, h0, m1, m0, s1, s0);
      m_st  = S_IDLE;
    end else if (sp) begin
      if (m_st == S_RUN) m_st = S_IDLE;
    end else if (st && m_st == S_IDLE) begin
      if (m_val > 0) m_st = S_RUN;
    end else if (en && m_st == S_RUN) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_st = S_DONE;
        m_dp = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    m_val = 0;
    m_st  = S_IDLE;
    m_dp  = 1'b0;
  endtask

  task automatic set_inputs(bit ld, bit st, bit sp, bit en,
                            int h1, int h0, int m1, int m0, int s1, int s0);
    bus.load  = ld;
    bus.start = st;
    bus.stop  = sp;
    bus.en    = en;
    bus.hd1   = 3'(h1);
    bus.hd0   = 4'(h0);
    bus.md1   = 3'(m1);
    bus.md0   = 4'(m0);
    bus.sd1   = 3'(s1);
    bus.sd0   = 4'(s0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, int e_sec, int e_st, bit e_done, bit e_dp);
    int hh, mm, ss;
    logic [21:0] exp_d, act_d;
    hh = e_sec / 3600;
    mm = (e_sec / 60) % 60;
    ss = e_sec % 60;
    exp_d = {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    act_d = {bus.hq1, bus.hq0, bus.mq1, bus.mq0, bus.sq1, bus.sq0};
    total++;
    if (act_d !== exp_d) begin
      bad++;
      $display("FAIL %s digits: got %0d%0d:%0d%0d:%0d%0d want %02d:%02d:%02d",
               tag, bus.hq1, bus.hq0, bus.mq1, bus.mq0, bus.sq1, bus.sq0, hh, mm, ss);
    end
    total++;
    if (bus.state !== 2'(e_st)) begin
      bad++;
      $display("FAIL %s state: got %b want %0d", tag, bus.state, e_st);
    end
    total++;
    if (bus.done !== e_done) begin
      bad++;
      $display("FAIL %s done: got %b want %0b", tag, bus.done, e_done);
    end
    total++;
    if (bus.done_p !== e_dp) begin
      bad++;
      $display("FAIL %s done_p: got %b want %0b", tag, bus.done_p, e_dp);
    end
  endtask

  initial begin
    // load 01:00:00, start, en
    vecs[0]  = mk(1,0,0,0, 0,1,0,0,0,0,   1, 0, 0, S_IDLE,0,0);
    vecs[1]  = mk(0,1,0,0, 0,0,0,0,0,0,   1, 0, 0, S_RUN, 0,0);
    vecs[2]  = mk(0,0,0,1, 0,0,0,0,0,0,   0,59,59, S_RUN, 0,0);
    // out-of-range preset clamps to 23:59:59; en in IDLE does nothing
    vecs[3]  = mk(1,0,0,0, 3,7,7,12,6,15, 23,59,59, S_IDLE,0,0);
    vecs[4]  = mk(0,0,0,1, 0,0,0,0,0,0,  23,59,59, S_IDLE,0,0);
    // start at zero stays IDLE
    vecs[5]  = mk(1,0,0,0, 0,0,0,0,0,0,   0, 0, 0, S_IDLE,0,0);
    vecs[6]  = mk(0,1,0,0, 0,0,0,0,0,0,   0, 0, 0, S_IDLE,0,0);
    // 20:00:00 -> 19:59:59 (hour borrow across tens)
    vecs[7]  = mk(1,0,0,0, 2,0,0,0,0,0,  20, 0, 0, S_IDLE,0,0);
    vecs[8]  = mk(0,1,0,0, 0,0,0,0,0,0,  20, 0, 0, S_RUN, 0,0);
    vecs[9]  = mk(0,0,0,1, 0,0,0,0,0,0,  19,59,59, S_RUN, 0,0);
    // 00:00:02 counts into DONE, then DONE ignores en/start/stop
    vecs[10] = mk(1,0,0,0, 0,0,0,0,0,2,   0, 0, 2, S_IDLE,0,0);
    vecs[11] = mk(0,1,0,0, 0,0,0,0,0,0,   0, 0, 2, S_RUN, 0,0);
    vecs[12] = mk(0,0,0,1, 0,0,0,0,0,0,   0, 0, 1, S_RUN, 0,0);
    vecs[13] = mk(0,0,0,1, 0,0,0,0,0,0,   0, 0, 0, S_DONE,1,1);
    vecs[14] = mk(0,0,0,1, 0,0,0,0,0,0,   0, 0, 0, S_DONE,1,0);
    vecs[15] = mk(0,1,0,0, 0,0,0,0,0,0,   0, 0, 0, S_DONE,1,0);
    vecs[16] = mk(0,0,1,0, 0,0,0,0,0,0,   0, 0, 0, S_DONE,1,0);
    // stop with en in RUN at 00:10:00, resume
    vecs[17] = mk(1,0,0,0, 0,0,1,0,0,0,   0,10, 0, S_IDLE,0,0);
    vecs[18] = mk(0,1,0,0, 0,0,0,0,0,0,   0,10, 0, S_RUN, 0,0);
    vecs[19] = mk(0,0,1,1, 0,0,0,0,0,0,   0,10, 0, S_IDLE,0,0);
    vecs[20] = mk(0,1,0,0, 0,0,0,0,0,0,   0,10, 0, S_RUN, 0,0);
    vecs[21] = mk(0,0,0,1, 0,0,0,0,0,0,   0, 9,59, S_RUN, 0,0);
    // stop outranks start, in RUN and in IDLE
    vecs[22] = mk(0,1,1,0, 0,0,0,0,0,0,   0, 9,59, S_IDLE,0,0);
    vecs[23] = mk(0,1,1,0, 0,0,0,0,0,0,   0, 9,59, S_IDLE,0,0);
    // hour clamps: 1x allows units 9, 2x allows units 3
    vecs[24] = mk(1,0,0,0, 1,12,0,0,0,0, 19, 0, 0, S_IDLE,0,0);
    vecs[25] = mk(1,0,0,0, 2,2,0,0,0,0,  22, 0, 0, S_IDLE,0,0);
    vecs[26] = mk(0,1,0,0, 0,0,0,0,0,0,  22, 0, 0, S_RUN, 0,0);
    vecs[27] = mk(0,0,0,1, 0,0,0,0,0,0,  21,59,59, S_RUN, 0,0);
    // load outranks everything; start+en in IDLE does not decrement
    vecs[28] = mk(1,1,1,1, 0,0,0,0,0,5,   0, 0, 5, S_IDLE,0,0);
    vecs[29] = mk(0,1,0,1, 0,0,0,0,0,0,   0, 0, 5, S_RUN, 0,0);
    vecs[30] = mk(0,0,0,1, 0,0,0,0,0,0,   0, 0, 4, S_RUN, 0,0);

    // ---- reset ----
    set_inputs(0,0,0,0, 0,0,0,0,0,0);
    clr = 1'b1;
    #1;
    check("reset_async", 0, S_IDLE, 1'b0, 1'b0);
    step();
    check("reset_held", 0, S_IDLE, 1'b0, 1'b0);
    clr = 1'b0;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      set_inputs(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].en,
                 vecs[i].h1, vecs[i].h0, vecs[i].m1, vecs[i].m0, vecs[i].s1, vecs[i].s0);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_sec, vecs[i].e_st, vecs[i].e_done, vecs[i].e_dp);
      $display("vec %0d: ld=%0b st=%0b sp=%0b en=%0b -> %0d%0d:%0d%0d:%0d%0d state=%0d done=%0b done_p=%0b",
               i, vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].en,
               bus.hq1, bus.hq0, bus.mq1, bus.mq0, bus.sq1, bus.sq0,
               bus.state, bus.done, bus.done_p);
    end

    // ---- clr between edges during RUN at 12:34:56 ----
    set_inputs(1,0,0,0, 1,2,3,4,5,6);
    step();
    check("clr_load", to_s(12,34,56), S_IDLE, 1'b0, 1'b0);
    set_inputs(0,1,0,0, 0,0,0,0,0,0);
    step();
    check("clr_run", to_s(12,34,56), S_RUN, 1'b0, 1'b0);
    set_inputs(0,0,0,1, 0,0,0,0,0,0);
    @(negedge clk);
    #1;
    clr = 1'b1;
    #1;
    check("clr_midcycle", 0, S_IDLE, 1'b0, 1'b0);
    $display("seq clr mid-RUN: %0d%0d:%0d%0d:%0d%0d state=%0d",
             bus.hq1, bus.hq0, bus.mq1, bus.mq0, bus.sq1, bus.sq0, bus.state);
    // clr held across an edge dominates load/start/en
    set_inputs(1,1,0,1, 1,2,3,4,5,6);
    step();
    check("clr_dominates", 0, S_IDLE, 1'b0, 1'b0);
    clr = 1'b0;
    set_inputs(0,1,0,0, 0,0,0,0,0,0);
    step();
    check("clr_after_start", 0, S_IDLE, 1'b0, 1'b0);

    // ---- clr out of DONE ----
    set_inputs(1,0,0,0, 0,0,0,0,0,1);
    step();
    set_inputs(0,1,0,0, 0,0,0,0,0,0);
    step();
    set_inputs(0,0,0,1, 0,0,0,0,0,0);
    step();
    check("done_entry", 0, S_DONE, 1'b1, 1'b1);
    set_inputs(0,0,0,0, 0,0,0,0,0,0);
    #2;
    clr = 1'b1;
    #1;
    check("clr_in_done", 0, S_IDLE, 1'b0, 1'b0);
    clr = 1'b0;
    step();
    check("idle_after_clr", 0, S_IDLE, 1'b0, 1'b0);
    $display("seq clr in DONE: state=%0d done=%0b", bus.state, bus.done);

    // ---- random vs. model ----
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      bit ld, st, sp, en;
      int h1, h0, m1, m0, s1, s0;
      if ($urandom_range(0, 199) == 0) begin
        clr = 1'b1;
        #1;
        model_clear();
        check($sformatf("rnd%0d_clr", n), m_val, m_st, m_st == S_DONE, m_dp);
        clr = 1'b0;
        continue;
      end
      ld = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 15);
      sp = ($urandom_range(0, 99) < 5);
      en = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 1) == 0) begin
        h1 = 0; h0 = 0; m1 = 0;
        m0 = $urandom_range(0, 1);
        s1 = $urandom_range(0, 7);
        s0 = $urandom_range(0, 15);
      end else begin
        h1 = $urandom_range(0, 7);
        h0 = $urandom_range(0, 15);
        m1 = $urandom_range(0, 7);
        m0 = $urandom_range(0, 15);
        s1 = $urandom_range(0, 7);
        s0 = $urandom_range(0, 15);
      end
      set_inputs(ld, st, sp, en, h1, h0, m1, m0, s1, s0);
      step();
      model_step(ld, st, sp, en, h1, h0, m1, m0, s1, s0);
      check($sformatf("rnd%0d", n), m_val, m_st, m_st == S_DONE, m_dp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
